// File: rtl/plab5_mcore_net_msg_to_mem_req_pkg.sv
// Shared types and field-width helpers for the bank-side network-to-memory request receiver.
// The core-side packer stores the request domain inverted in the payload MSB.
package plab5_mcore_net_msg_to_mem_req_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    localparam int   MEM_REQ_TYPE_NBITS     = 3;
    localparam logic DOMAIN_STORED_INVERTED = 1'b1;

    // {type, opaque, addr, len, data}; len counts bytes of the data word
    function automatic int mem_req_nbits(input int mo, input int ma, input int md);
        return MEM_REQ_TYPE_NBITS + mo + ma + $clog2(md / 8) + md;
    endfunction

    // {dest, src, opaque, payload}
    function automatic int net_msg_nbits(input int p, input int o, input int s);
        return 2 * s + o + p;
    endfunction

    function automatic logic recover_domain(input logic stored_bit);
        return stored_bit ^ DOMAIN_STORED_INVERTED;
    endfunction

endpackage

// File: rtl/plab5_mcore_net_msg_to_mem_req_queue.sv
// Two-entry normal queue: no bypass, enq_rdy depends only on current occupancy.
module plab5_mcore_net_msg_to_mem_req_queue #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enq_val,
    output logic               o_enq_rdy,
    input  logic [p_nbits-1:0] i_enq_msg,
    output logic               o_deq_val,
    input  logic               i_deq_rdy,
    output logic [p_nbits-1:0] o_deq_msg
);

    logic [p_nbits-1:0] r_entry [2];
    logic               r_head;
    logic               r_tail;
    logic [1:0]         r_count;
    logic               w_enq;
    logic               w_deq;

    assign o_enq_rdy = !reset && (r_count != 2'd2);
    assign o_deq_val = !reset && (r_count != 2'd0);
    assign w_enq     = i_enq_val && o_enq_rdy;
    assign w_deq     = o_deq_val && i_deq_rdy;
    assign o_deq_msg = r_entry[r_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_tail <= ~r_tail;
            if (w_deq) r_head <= ~r_head;
            r_count <= r_count + 2'(w_enq) - 2'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_entry[r_tail] <= i_enq_msg;
    end

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_req.sv
// Joins one control flit and one data flit in arrival order into a memory request,
// recovers the security domain from the payload MSB and buffers it in a 2-entry queue.
module plab5_mcore_net_msg_to_mem_req
    import plab5_mcore_net_msg_to_mem_req_pkg::*;
#(
    parameter int p_net_dest          = 0,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_addr_nbits    = 32,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3,
    localparam int c_mreq_nbits = mem_req_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
    localparam int npc          = c_mreq_nbits - p_mem_data_nbits,
    localparam int c_ctrl_nbits = net_msg_nbits(npc + 1, p_net_opaque_nbits, p_net_srcdest_nbits)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           net_ctrl_val,
    output logic                           net_ctrl_rdy,
    input  logic [c_ctrl_nbits-1:0]        net_ctrl_msg,
    input  logic                           net_data_val,
    output logic                           net_data_rdy,
    input  logic [p_mem_data_nbits-1:0]    net_data_msg,
    output logic                           mem_req_val,
    input  logic                           mem_req_rdy,
    output logic [c_mreq_nbits-1:0]        mem_req_msg,
    output logic                           mem_req_domain,
    output logic [p_net_srcdest_nbits-1:0] mem_req_src,
    output logic                           dest_err
);

    localparam int ns          = p_net_srcdest_nbits;
    localparam int c_outq_bits = 1 + ns + c_mreq_nbits;
    localparam logic [ns-1:0] c_dest = ns'(p_net_dest);

    buf_state_e r_ctrl_state, w_ctrl_state_nxt;
    buf_state_e r_data_state, w_data_state_nxt;

    logic [ns+npc:0]               r_ctrl_fields;   // {src, payload}
    logic [p_mem_data_nbits-1:0]   r_data_msg;
    logic                          r_dest_err;

    logic                          w_ctrl_full, w_data_full;
    logic                          w_ctrl_enq, w_data_enq;
    logic                          w_join;
    logic                          w_outq_enq_rdy;
    logic [c_outq_bits-1:0]        w_outq_enq_msg;
    logic [c_outq_bits-1:0]        w_outq_deq_msg;
    logic [ns-1:0]                 w_in_dest, w_in_src;
    logic                          w_unused_net_opaque;

    assign w_in_dest           = net_ctrl_msg[c_ctrl_nbits-1 -: ns];
    assign w_in_src            = net_ctrl_msg[c_ctrl_nbits-ns-1 -: ns];
    assign w_unused_net_opaque = ^net_ctrl_msg[npc+p_net_opaque_nbits:npc+1];

    assign w_ctrl_enq = net_ctrl_val && net_ctrl_rdy;
    assign w_data_enq = net_data_val && net_data_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_state <= BUF_EMPTY;
            r_data_state <= BUF_EMPTY;
        end else begin
            r_ctrl_state <= w_ctrl_state_nxt;
            r_data_state <= w_data_state_nxt;
        end
    end

    always_comb begin
        w_ctrl_state_nxt = r_ctrl_state;
        w_data_state_nxt = r_data_state;
        case (r_ctrl_state)
            BUF_EMPTY: if (w_ctrl_enq)            w_ctrl_state_nxt = BUF_FULL;
            BUF_FULL:  if (w_join && !w_ctrl_enq) w_ctrl_state_nxt = BUF_EMPTY;
            default:                              w_ctrl_state_nxt = BUF_EMPTY;
        endcase
        case (r_data_state)
            BUF_EMPTY: if (w_data_enq)            w_data_state_nxt = BUF_FULL;
            BUF_FULL:  if (w_join && !w_data_enq) w_data_state_nxt = BUF_EMPTY;
            default:                              w_data_state_nxt = BUF_EMPTY;
        endcase
    end

    // A buffer accepts while empty or while its current flit leaves in a join
    always_comb begin
        w_ctrl_full  = (r_ctrl_state == BUF_FULL);
        w_data_full  = (r_data_state == BUF_FULL);
        w_join       = w_ctrl_full && w_data_full && w_outq_enq_rdy;
        net_ctrl_rdy = !reset && (!w_ctrl_full || w_join);
        net_data_rdy = !reset && (!w_data_full || w_join);
    end

    always_ff @(posedge clk) begin
        if (w_ctrl_enq) r_ctrl_fields <= {w_in_src, net_ctrl_msg[npc:0]};
        if (w_data_enq) r_data_msg    <= net_data_msg;
    end

    // Mismatched dest is flagged but the flit is still processed
    always_ff @(posedge clk) begin
        if (reset)                                  r_dest_err <= 1'b0;
        else if (w_ctrl_enq && w_in_dest != c_dest) r_dest_err <= 1'b1;
    end

    assign dest_err = r_dest_err;

    assign w_outq_enq_msg = {recover_domain(r_ctrl_fields[npc]),
                             r_ctrl_fields[ns+npc:npc+1],
                             r_ctrl_fields[npc-1:0],
                             r_data_msg};

    plab5_mcore_net_msg_to_mem_req_queue #(
        .p_nbits (c_outq_bits)
    ) u_outq (
        .clk       (clk),
        .reset     (reset),
        .i_enq_val (w_join),
        .o_enq_rdy (w_outq_enq_rdy),
        .i_enq_msg (w_outq_enq_msg),
        .o_deq_val (mem_req_val),
        .i_deq_rdy (mem_req_rdy),
        .o_deq_msg (w_outq_deq_msg)
    );

    assign {mem_req_domain, mem_req_src, mem_req_msg} = w_outq_deq_msg;

endmodule
